// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int unsigned       DEF_INST_BYTES = 4;
  localparam logic [INST_W-1:0] NOP_INST       = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues held ce/addr requests to the
// instruction memory and loads the IF/ID register under stall/redirect control.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned INST_BYTES = DEF_INST_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] id_addr,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] id_addr_n, id_inst_n;
  logic        id_valid_n;
  logic [31:0] buf_addr, buf_addr_n;
  logic [31:0] buf_inst, buf_inst_n;
  logic [31:0] redir_pc, redir_pc_n;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  // Request strobe is a pure decode of the state register; address is the PC.
  assign mem_ce   = (state == ST_FETCH) || (state == ST_DRAIN);
  assign mem_addr = pc;

  assign tgt    = redirect_addr & ~32'h0000_0003;
  assign pc_inc = pc + 32'(INST_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      id_addr  <= 32'h0000_0000;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      buf_addr <= 32'h0000_0000;
      buf_inst <= NOP_INST;
      redir_pc <= 32'h0000_0000;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      id_addr  <= id_addr_n;
      id_inst  <= id_inst_n;
      id_valid <= id_valid_n;
      buf_addr <= buf_addr_n;
      buf_inst <= buf_inst_n;
      redir_pc <= redir_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    id_addr_n  = id_addr;
    id_inst_n  = id_inst;
    id_valid_n = id_valid;
    buf_addr_n = buf_addr;
    buf_inst_n = buf_inst;
    redir_pc_n = redir_pc;

    case (state)
      ST_IDLE: state_n = ST_FETCH;

      ST_FETCH: begin
        if (mem_rvalid) begin
          if (redirect) begin
            pc_n       = tgt;
            id_valid_n = 1'b0;
          end else if (stall) begin
            // ID is full: park the returned word so the port can be released.
            buf_addr_n = pc;
            buf_inst_n = mem_rdata;
            pc_n       = pc_inc;
            state_n    = ST_HOLD;
          end else begin
            id_addr_n  = pc;
            id_inst_n  = mem_rdata;
            id_valid_n = 1'b1;
            pc_n       = pc_inc;
          end
        end else if (redirect) begin
          // Request in flight must complete at the old address before retargeting.
          redir_pc_n = tgt;
          id_valid_n = 1'b0;
          state_n    = ST_DRAIN;
        end else if (!stall) begin
          id_valid_n = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_n       = tgt;
          id_valid_n = 1'b0;
          state_n    = ST_FETCH;
        end else if (!stall) begin
          id_addr_n  = buf_addr;
          id_inst_n  = buf_inst;
          id_valid_n = 1'b1;
          state_n    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        id_valid_n = 1'b0;
        if (redirect) begin
          redir_pc_n = tgt;
        end
        if (mem_rvalid) begin
          pc_n    = redirect ? tgt : redir_pc;
          state_n = ST_FETCH;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// checked against an instruction-stream model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_ce;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] id_addr;
  logic [31:0] id_inst;
  logic        id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory wait-state control: waits_cfg < 0 draws a random latency per request.
  int waits_cfg = 0;
  int wait_left = -1;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_ce        (mem_ce),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .id_addr       (id_addr),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a + 32'h0000_0100;
  endfunction

  // Variable-latency memory: answers the held request after wait_left idle cycles.
  task automatic drive_mem();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_BEEF;
    if (mem_ce) begin
      if (wait_left < 0) wait_left = (waits_cfg < 0) ? int'($urandom_range(0, 3)) : waits_cfg;
      if (wait_left == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rom(mem_addr);
        wait_left  = -1;
      end else begin
        wait_left = wait_left - 1;
      end
    end
  endtask

  task automatic tick();
    drive_mem();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    waits_cfg = 0; wait_left = -1;
    @(negedge clk); tick();
    n_checks++;
    if ({mem_ce, id_valid, id_addr, id_inst, mem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0000_0013, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_values: ce=%0b v=%0b ida=%h idi=%h ma=%h required 0 0 0 00000013 0",
               mem_ce, id_valid, id_addr, id_inst, mem_addr);
    end
    rst = 1'b0;
    n_checks++;
    if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL idle_ce: got %0b required 0", mem_ce); end
  endtask

  task automatic test_stream();
    tick();
    n_checks++;
    if (mem_ce !== 1'b1 || mem_addr !== 32'h0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: ce=%0b ma=%h v=%0b required 1 0 0", mem_ce, mem_addr, id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_addr !== 32'(4 * i) || id_inst !== 32'(4 * i + 32'h100)) begin
        n_fail++;
        $display("FAIL stream[%0d]: v=%0b a=%h i=%h required 1 %h %h", i, id_valid, id_addr, id_inst,
                 32'(4 * i), 32'(4 * i + 32'h100));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (id_valid !== 1'b1 || id_addr !== 32'h8 || mem_ce !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%0b a=%h ce=%0b required 1 8 0", i, id_valid, id_addr, mem_ce);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'hC || id_inst !== 32'h10C) begin
      n_fail++;
      $display("FAIL stall_release: v=%0b a=%h i=%h required 1 c 10c", id_valid, id_addr, id_inst);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_next: v=%0b a=%h required 1 10", id_valid, id_addr);
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_addr = 32'h200;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (id_valid !== 1'b0 || mem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL redirect_flush: v=%0b ma=%h required 0 200", id_valid, mem_addr);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'h200 || id_inst !== 32'h300) begin
      n_fail++;
      $display("FAIL redirect_target: v=%0b a=%h i=%h required 1 200 300", id_valid, id_addr, id_inst);
    end
  endtask

  task automatic test_drain();
    waits_cfg = 3;
    redirect = 1'b1; redirect_addr = 32'h80;
    tick();
    redirect_addr = 32'h90;
    n_checks++;
    if (id_valid !== 1'b0 || mem_ce !== 1'b1 || mem_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL drain_enter: v=%0b ce=%0b ma=%h required 0 1 204", id_valid, mem_ce, mem_addr);
    end
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (mem_ce !== 1'b1 || mem_addr !== 32'h204 || id_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: ce=%0b ma=%h v=%0b required 1 204 0", i, mem_ce, mem_addr, id_valid);
      end
      tick();
    end
    waits_cfg = 0;
    n_checks++;
    if (mem_ce !== 1'b1 || mem_addr !== 32'h90 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit: ce=%0b ma=%h v=%0b required 1 90 0", mem_ce, mem_addr, id_valid);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'h90 || id_inst !== 32'h190) begin
      n_fail++;
      $display("FAIL drain_target: v=%0b a=%h i=%h required 1 90 190", id_valid, id_addr, id_inst);
    end
  endtask

  task automatic test_hold_redirect();
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_addr = 32'h40;
    tick();
    stall = 1'b0; redirect = 1'b0;
    n_checks++;
    if (id_valid !== 1'b0 || mem_ce !== 1'b1 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL hold_redirect: v=%0b ce=%0b ma=%h required 0 1 40", id_valid, mem_ce, mem_addr);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL hold_redirect_next: v=%0b a=%h required 1 40", id_valid, id_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (mem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_target: ma=%h required fffffffc", mem_addr);
    end
    tick();
    n_checks++;
    if (id_addr !== 32'hFFFF_FFFC || id_valid !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: a=%h v=%0b ma=%h required fffffffc 1 0", id_addr, id_valid, mem_addr);
    end
    waits_cfg = 3;
    redirect = 1'b1; redirect_addr = 32'h300;
    tick();
    redirect = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({mem_ce, id_valid, id_addr, id_inst, mem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0000_0013, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_drain: ce=%0b v=%0b ida=%h idi=%h ma=%h required 0 0 0 00000013 0",
               mem_ce, id_valid, id_addr, id_inst, mem_addr);
    end
    rst = 1'b0; waits_cfg = 0; wait_left = -1;
    tick();
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_addr !== 32'h0 || id_inst !== 32'h100) begin
      n_fail++;
      $display("FAIL reset_resume: v=%0b a=%h i=%h required 1 0 100", id_valid, id_addr, id_inst);
    end
  endtask

  // Random traffic against a stream model: every instruction ID consumes must be
  // the next one in program order since the last redirect, carrying ROM data.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        flush_pending;
    logic        req_open;
    logic [31:0] req_addr;
    int          consumed;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
    rst = 1'b0; waits_cfg = -1; wait_left = -1;
    exp_pc = 32'h0; flush_pending = 1'b0; req_open = 1'b0; req_addr = 32'h0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (flush_pending) begin
        n_checks++;
        if (id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_flush cyc %0d: v=%0b required 0", cyc, id_valid);
        end
      end
      if (req_open) begin
        n_checks++;
        if (mem_ce !== 1'b1 || mem_addr !== req_addr) begin
          n_fail++;
          $display("FAIL rnd_req_stable cyc %0d: ce=%0b ma=%h required 1 %h", cyc, mem_ce, mem_addr, req_addr);
        end
      end
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 8);
      redirect_addr = $urandom;
      drive_mem();
      if (id_valid && !stall && !redirect) begin
        n_checks++;
        if (id_addr !== exp_pc || id_inst !== rom(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_stream cyc %0d: a=%h i=%h required %h %h", cyc, id_addr, id_inst,
                   exp_pc, rom(exp_pc));
        end
        exp_pc = id_addr + 32'd4;
        consumed++;
      end
      if (redirect) exp_pc = redirect_addr & ~32'h3;
      flush_pending = redirect;
      req_open = mem_ce && !mem_rvalid;
      req_addr = mem_addr;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (consumed < 100) begin
      n_fail++;
      $display("FAIL rnd_progress: consumed %0d required >= 100", consumed);
    end
    redirect = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drain();
    test_hold_redirect();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch datapath: owns the PC, drives the instruction-memory port with a ce/addr request held until a response arrives, and loads the IF/ID pipeline register (id_addr/id_inst/id_valid). Handles ID-stage back-pressure (stall), branch/jump redirects (flush), and variable-latency memory, including redirects that arrive while a fetch is outstanding. Sits between the hazard/branch logic and the instruction ROM, replacing free-running PC fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
INST_BYTES, 4, PC increment per instruction

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  ID cannot accept a new instruction; IF/ID holds
redirect  in  1  branch/jump taken; flush IF/ID and refetch
redirect_addr  in  32  redirect target; bits [1:0] ignored (treated as 0)
mem_ce  out  1  instruction-memory request
mem_addr  out  32  fetch address; stable while mem_ce high until mem_rvalid
mem_rvalid  in  1  response valid; completes the current request
mem_rdata  in  32  instruction word, valid with mem_rvalid
id_addr  out  32  IF/ID PC
id_inst  out  32  IF/ID instruction
id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst. Priority: rst > redirect > stall.
- Reset values: state=IDLE, pc=RESET_PC, mem_ce=0, id_valid=0, id_addr=0, id_inst=32'h0000_0013 (NOP). Reset mid-fetch abandons the outstanding request. The memory is required to tolerate a dropped ce.
- mem_ce is decoded from state: 1 in FETCH and DRAIN, 0 in IDLE and HOLD. mem_addr=pc register.
- Memory latency is 0 or more cycles. mem_rvalid may assert in the first ce cycle, e.g. a combinational ROM with rvalid=ce, giving 1 instruction/cycle throughput.
- IDLE: mem_ce=0 → FETCH unconditionally next cycle.
- FETCH:
  - rvalid & redirect: discard rdata, pc<=redirect_addr, id_valid<=0, stay FETCH.
  - rvalid & stall: buf_addr<=pc, buf_inst<=rdata, pc<=pc+INST_BYTES, IF/ID held → HOLD.
  - rvalid & !stall: id_addr<=pc, id_inst<=rdata, id_valid<=1, pc<=pc+INST_BYTES, stay FETCH.
  - !rvalid & redirect: redir_pc<=redirect_addr, id_valid<=0 → DRAIN. pc/mem_addr are unchanged.
  - !rvalid & stall: IF/ID held, stay FETCH.
  - !rvalid & !stall: id_valid<=0 (bubble), stay FETCH.
- HOLD (mem_ce=0):
  - redirect: drop buffer, pc<=redirect_addr, id_valid<=0 → FETCH.
  - !stall: id_addr<=buf_addr, id_inst<=buf_inst, id_valid<=1 → FETCH.
  - stall: stay HOLD.
- DRAIN (mem_ce=1, mem_addr = old pc):
  - A further redirect overwrites redir_pc (latest wins).
  - On rvalid: discard rdata, pc<=redir_pc (or the same-cycle redirect_addr if redirect=1) → FETCH.
  - id_valid=0 throughout.
- Redirect always clears id_valid on the next edge, even when stall=1 (flush dominates stall). id_addr/id_inst may keep stale values when id_valid=0.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of pc are always 0.
- No instruction is ever skipped or delivered twice on the sequential path.

Decomposition:
- Package fetch_pkg holds:
  - state encoding: IDLE, FETCH, HOLD, DRAIN (2 bits)
  - NOP_INST = 32'h0000_0013
  - default RESET_PC and INST_BYTES
- Single module with no sub-module. PC, 1-entry buffer (buf_addr/buf_inst), redir_pc and the FSM are small enough to live together.

Test Plan:
- Reset, then ROM with rvalid=ce and rdata=addr+32'h100: id_addr 0,4,8 on consecutive cycles with id_valid=1 and id_inst 0x100,0x104,0x108. mem_ce=0 during reset and the IDLE cycle.
- Stall 3 cycles while id_addr=8: IF/ID holds 8 and mem_ce=0 in HOLD. On release, id_addr goes 0xC then 0x10, with no skip or duplicate.
- Redirect to 0x200 with rvalid the same cycle: next cycle id_valid=0 and mem_addr=0x200. Then id_addr=0x200 with id_valid=1.
- 3-wait-state memory, redirect to 0x80 in wait cycle 1, then redirect to 0x90 in DRAIN: mem_addr stays at the old PC until rvalid, the response is discarded, and the next request is 0x90.
- Stall and redirect=1 (target 0x40) both asserted in HOLD: buffer dropped, id_valid=0, next fetch at 0x40.
- Redirect to 0xFFFF_FFFC: after it, next mem_addr is 0x0. Assert rst mid-DRAIN: outputs return to reset values, then fetch resumes at RESET_PC.
